// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port arbiter and sequencer in front of the single-ported 256 x 32 data memory.
// Optional feature macro: DM_ARB_ROUND_ROBIN_EN (round-robin tie-breaking instead of fixed port-0 priority).
module dm_arbiter #(
    parameter int unsigned READ_LAT = 1,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_w_data,
    output logic              dm_r_mem,
    output logic              dm_w_mem,
    input  logic [31:0]       dm_r_data,
    output logic              busy
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 2;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LAT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RWAIT  = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                port_q, port_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   dm_addr_q, dm_addr_d;
    logic [DATA_W-1:0]   dm_w_data_q, dm_w_data_d;
    logic                dm_r_mem_q, dm_r_mem_d;
    logic                dm_w_mem_q, dm_w_mem_d;
    logic                m0_gnt_q, m0_gnt_d;
    logic                m1_gnt_q, m1_gnt_d;
    logic                m0_rvalid_q, m0_rvalid_d;
    logic                m1_rvalid_q, m1_rvalid_d;
    logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;
    logic                busy_q, busy_d;
    logic                win_c;

`ifdef DM_ARB_ROUND_ROBIN_EN
    logic last_q, last_d;

    // Ties go to the port not served last; the pointer tracks the port in ACCESS.
    always_comb begin
        win_c  = ~m0_req;
        if (m0_req && m1_req) begin
            win_c = ~last_q;
        end
        last_d = (state_q == ACCESS) ? port_q : last_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        win_c = ~m0_req;
    end
`endif

    // Next-state and registered-output values; outputs are computed for the state being entered.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        port_d      = port_q;
        we_d        = we_q;
        dm_addr_d   = dm_addr_q;
        dm_w_data_d = dm_w_data_q;
        dm_r_mem_d  = 1'b0;
        dm_w_mem_d  = 1'b0;
        m0_gnt_d    = 1'b0;
        m1_gnt_d    = 1'b0;
        m0_rvalid_d = 1'b0;
        m1_rvalid_d = 1'b0;
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;

        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    port_d      = win_c;
                    we_d        = win_c ? m1_we : m0_we;
                    dm_addr_d   = win_c ? m1_addr : m0_addr;
                    dm_w_data_d = win_c ? m1_wdata : m0_wdata;
                    dm_w_mem_d  = win_c ? m1_we : m0_we;
                    dm_r_mem_d  = win_c ? ~m1_we : ~m0_we;
                    m0_gnt_d    = ~win_c;
                    m1_gnt_d    = win_c;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = IDLE;
                end else if (READ_LAT == 1) begin
                    state_d = RESP;
                end else begin
                    cnt_d   = CNT_LOAD;
                    state_d = RWAIT;
                end
            end
            RWAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == RESP) begin
            if (port_q) begin
                m1_rvalid_d = 1'b1;
                m1_rdata_d  = dm_r_data;
            end else begin
                m0_rvalid_d = 1'b1;
                m0_rdata_d  = dm_r_data;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            port_q      <= 1'b0;
            we_q        <= 1'b0;
            dm_addr_q   <= '0;
            dm_w_data_q <= '0;
            dm_r_mem_q  <= 1'b0;
            dm_w_mem_q  <= 1'b0;
            m0_gnt_q    <= 1'b0;
            m1_gnt_q    <= 1'b0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            port_q      <= port_d;
            we_q        <= we_d;
            dm_addr_q   <= dm_addr_d;
            dm_w_data_q <= dm_w_data_d;
            dm_r_mem_q  <= dm_r_mem_d;
            dm_w_mem_q  <= dm_w_mem_d;
            m0_gnt_q    <= m0_gnt_d;
            m1_gnt_q    <= m1_gnt_d;
            m0_rvalid_q <= m0_rvalid_d;
            m1_rvalid_q <= m1_rvalid_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign m0_gnt    = m0_gnt_q;
    assign m1_gnt    = m1_gnt_q;
    assign m0_rvalid = m0_rvalid_q;
    assign m1_rvalid = m1_rvalid_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;
    assign dm_addr   = dm_addr_q;
    assign dm_w_data = dm_w_data_q;
    assign dm_r_mem  = dm_r_mem_q;
    assign dm_w_mem  = dm_w_mem_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: two dm_arbiter instances (READ_LAT 1 and 3) against a transaction-timeline reference model.
// Honours DM_ARB_ROUND_ROBIN_EN for the expected tie-break order.
module tb_dm_arbiter;

    localparam int unsigned NI = 2;
    localparam int unsigned AW = 32;

    logic        clk;
    logic        rst;
    logic        req    [NI][2];
    logic        we     [NI][2];
    logic [31:0] addr   [NI][2];
    logic [31:0] wdata  [NI][2];
    logic        gnt    [NI][2];
    logic        rvalid [NI][2];
    logic [31:0] rdata  [NI][2];
    logic [31:0] dm_addr   [NI];
    logic [31:0] dm_w_data [NI];
    logic [31:0] dm_r_data [NI];
    logic        dm_r_mem  [NI];
    logic        dm_w_mem  [NI];
    logic        busy      [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dm_arbiter #(.READ_LAT(g == 0 ? 1 : 3), .ADDR_W(AW)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .m0_req    (req[g][0]),
            .m0_we     (we[g][0]),
            .m0_addr   (addr[g][0]),
            .m0_wdata  (wdata[g][0]),
            .m0_gnt    (gnt[g][0]),
            .m0_rvalid (rvalid[g][0]),
            .m0_rdata  (rdata[g][0]),
            .m1_req    (req[g][1]),
            .m1_we     (we[g][1]),
            .m1_addr   (addr[g][1]),
            .m1_wdata  (wdata[g][1]),
            .m1_gnt    (gnt[g][1]),
            .m1_rvalid (rvalid[g][1]),
            .m1_rdata  (rdata[g][1]),
            .dm_addr   (dm_addr[g]),
            .dm_w_data (dm_w_data[g]),
            .dm_r_mem  (dm_r_mem[g]),
            .dm_w_mem  (dm_w_mem[g]),
            .dm_r_data (dm_r_data[g]),
            .busy      (busy[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    bit tmo    = 1'b0;

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Memory emulation and reference model state.
    logic [31:0] sim_mem [NI][256];
    logic [31:0] ref_mem [NI][256];
    int          rd_cnt  [NI];
    bit          rd_pend [NI];
    logic [31:0] rd_addr [NI];

    bit          mdl_on  [NI];
    bit          act     [NI];
    bit          zero_cyc[NI];
    int          ts      [NI];
    int          te      [NI];
    int          tp      [NI];
    bit          twe     [NI];
    logic [31:0] taddr   [NI];
    logic [31:0] twd     [NI];
    logic [31:0] exp_rd  [NI][2];
    bit          last    [NI];

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < NI; i++) begin
            bit in_txn;
            bit acc;
            int win;
            // Memory: read data becomes valid READ_LAT-1 negedges after the strobe cycle, garbage before.
            if (dm_w_mem[i] === 1'b1) sim_mem[i][dm_addr[i][9:2]] = dm_w_data[i];
            if (dm_r_mem[i] === 1'b1) begin
                rd_cnt[i]    = lat(i) - 1;
                rd_addr[i]   = dm_addr[i];
                rd_pend[i]   = 1'b1;
                dm_r_data[i] = $urandom;
            end else if (rd_pend[i] && rd_cnt[i] > 0) begin
                rd_cnt[i]--;
            end
            if (rd_pend[i] && rd_cnt[i] == 0) begin
                dm_r_data[i] = sim_mem[i][rd_addr[i][9:2]];
                rd_pend[i]   = 1'b0;
            end

            if (mdl_on[i]) begin
                in_txn = act[i] && cyc >= ts[i] && cyc < te[i];
                acc    = in_txn && cyc == ts[i];
                check($sformatf("i%0d busy", i), 32'(busy[i]), 32'(in_txn));
                check($sformatf("i%0d r_mem", i), 32'(dm_r_mem[i]), 32'(acc && !twe[i]));
                check($sformatf("i%0d w_mem", i), 32'(dm_w_mem[i]), 32'(acc && twe[i]));
                check($sformatf("i%0d strobe_excl", i), 32'(dm_r_mem[i] & dm_w_mem[i]), 32'd0);
                if (in_txn) begin
                    check($sformatf("i%0d dm_addr", i), dm_addr[i], taddr[i]);
                    check($sformatf("i%0d dm_w_data", i), dm_w_data[i], twd[i]);
                end
                if (zero_cyc[i]) begin
                    check($sformatf("i%0d dm_addr_rst", i), dm_addr[i], 32'd0);
                    check($sformatf("i%0d dm_w_data_rst", i), dm_w_data[i], 32'd0);
                end
                for (int p = 0; p < 2; p++) begin
                    bit rv;
                    rv = act[i] && !twe[i] && tp[i] == p && cyc == ts[i] + lat(i);
                    if (rv) exp_rd[i][p] = ref_mem[i][taddr[i][9:2]];
                    check($sformatf("i%0d gnt%0d", i, p), 32'(gnt[i][p]), 32'(acc && tp[i] == p));
                    check($sformatf("i%0d rvalid%0d", i, p), 32'(rvalid[i][p]), 32'(rv));
                    check($sformatf("i%0d rdata%0d", i, p), rdata[i][p], exp_rd[i][p]);
                end
            end

            // Advance: decide what the coming edge does.
            zero_cyc[i] = 1'b0;
            if (rst) begin
                mdl_on[i]   = 1'b1;
                act[i]      = 1'b0;
                last[i]     = 1'b1;
                exp_rd[i][0] = 32'd0;
                exp_rd[i][1] = 32'd0;
                zero_cyc[i] = 1'b1;
            end else if (mdl_on[i] && (!act[i] || cyc >= te[i]) && (req[i][0] || req[i][1])) begin
`ifdef DM_ARB_ROUND_ROBIN_EN
                win = (req[i][0] && req[i][1]) ? (last[i] ? 0 : 1) : (req[i][0] ? 0 : 1);
`else
                win = req[i][0] ? 0 : 1;
`endif
                act[i]   = 1'b1;
                tp[i]    = win;
                twe[i]   = we[i][win];
                taddr[i] = addr[i][win];
                twd[i]   = wdata[i][win];
                ts[i]    = cyc + 1;
                te[i]    = ts[i] + (twe[i] ? 1 : lat(i) + 1);
                last[i]  = (win == 1);
                if (twe[i]) ref_mem[i][taddr[i][9:2]] = twd[i];
            end
        end
        check("timeout", 32'(tmo), 32'd0);
    end

    function automatic logic [31:0] rand_addr();
        return ($urandom & 32'hFFFF_FC03) | (32'($urandom_range(0, 31)) << 2);
    endfunction

    task automatic set_req(input int i, input int p, input bit w, input logic [31:0] a, input logic [31:0] d);
        req[i][p]   = 1'b1;
        we[i][p]    = w;
        addr[i][p]  = a;
        wdata[i][p] = d;
    endtask

    task automatic step(input bit rnd);
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (gnt[i][p]) begin
                    req[i][p] = 1'b0;
                    if (rnd && $urandom_range(0, 1) == 1)
                        set_req(i, p, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
                end
                if (rnd && !req[i][p] && $urandom_range(0, 2) == 0)
                    set_req(i, p, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
            end
        end
    endtask

    // Raise a request and return in its grant cycle.
    task automatic xfer(input int i, input int p, input bit w, input logic [31:0] a, input logic [31:0] d);
        bit got;
        got = 1'b0;
        set_req(i, p, w, a, d);
        for (int k = 0; k < 50 && !got; k++) begin
            step(1'b0);
            got = gnt[i][p];
        end
        if (!got) tmo = 1'b1;
    endtask

    task automatic wait_idle(input int i);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            step(1'b0);
            done = !req[i][0] && !req[i][1] && !busy[i];
        end
        if (!done) tmo = 1'b1;
    endtask

    initial begin
        int ngr;
        logic [31:0] w;
        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            mdl_on[i] = 1'b0;
            act[i] = 1'b0;
            rd_pend[i] = 1'b0;
            rd_cnt[i] = 0;
            for (int p = 0; p < 2; p++) begin
                req[i][p] = 1'b0; we[i][p] = 1'b0; addr[i][p] = '0; wdata[i][p] = '0;
            end
            for (int k = 0; k < 256; k++) begin
                w = $urandom;
                sim_mem[i][k] = w;
                ref_mem[i][k] = w;
            end
        end
        sim_mem[1][8] = 32'h1234_5678;
        ref_mem[1][8] = 32'h1234_5678;
        repeat (3) step(1'b0);
        rst = 1'b0;
        step(1'b0);

        // Port 0 write then read-back, READ_LAT=1.
        xfer(0, 0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        xfer(0, 0, 1'b0, 32'h10, 32'h0);
        wait_idle(0);

        // Simultaneous reads from both ports.
        set_req(0, 0, 1'b0, 32'h04, 32'h0);
        set_req(0, 1, 1'b0, 32'h08, 32'h0);
        wait_idle(0);

        // READ_LAT=3, port 1 reads a preloaded word.
        xfer(1, 1, 1'b0, 32'h20, 32'h0);
        wait_idle(1);

        // Reset during RWAIT, then a normal write and read-back.
        xfer(1, 0, 1'b0, 32'h30, 32'h0);
        step(1'b0);
        rst = 1'b1;
        step(1'b0);
        rst = 1'b0;
        step(1'b0);
        xfer(1, 0, 1'b1, 32'h44, 32'hA5A5_0001);
        xfer(1, 0, 1'b0, 32'h44, 32'h0);
        wait_idle(1);

        // Both ports requesting continuously: tie-break order.
        set_req(0, 0, 1'b1, 32'h80, 32'h100);
        set_req(0, 1, 1'b1, 32'h84, 32'h101);
        ngr = 0;
        for (int k = 0; k < 60 && ngr < 4; k++) begin
            step(1'b0);
            for (int p = 0; p < 2; p++) begin
                if (gnt[0][p]) begin
                    ngr++;
                    if (ngr < 4) set_req(0, p, 1'b1, 32'h80 + 32'(4 * p), 32'(ngr));
                end
            end
        end
        if (ngr < 4) tmo = 1'b1;
        wait_idle(0);

        // Back-to-back writes and read-back.
        xfer(0, 0, 1'b1, 32'h00, 32'h1111_0000);
        xfer(0, 0, 1'b1, 32'h04, 32'h2222_0004);
        xfer(0, 0, 1'b1, 32'h08, 32'h3333_0008);
        xfer(0, 0, 1'b0, 32'h00, 32'h0);
        xfer(0, 0, 1'b0, 32'h04, 32'h0);
        xfer(0, 0, 1'b0, 32'h08, 32'h0);
        wait_idle(0);

        // Random traffic on both instances with occasional resets.
        for (int k = 0; k < 600; k++) begin
            step(1'b1);
            rst = ($urandom_range(0, 99) == 0);
        end
        rst = 1'b0;
        wait_idle(0);
        wait_idle(1);
        repeat (3) step(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
